// File: rtl/half_adder_bist.sv
// Built-in self-test controller for the combinational half adder.
// Walks a/b through 00, 01, 10, 11, holding each vector for HOLD_CYCLES
// clocks, samples sum/cout on the last hold cycle and records failures.
module half_adder_bist #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       sum,
    input  logic       cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    vec;
    logic [CW-1:0] cnt;
    logic          last_hold;
    logic          mismatch;
    logic          launch;

    // Decode of hold-end, response check and run launch
    always_comb begin
        last_hold = (cnt == CNT_LAST);
        mismatch  = (sum != (vec[1] ^ vec[0])) || (cout != (vec[1] & vec[0]));
        launch    = start && ((state == IDLE) || (state == DONE));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY:   if (last_hold && (vec == 2'd3)) state_nxt = DONE;
            DONE:    if (start) state_nxt = APPLY;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        a    = 1'b0;
        b    = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        unique case (state)
            APPLY: begin
                a    = vec[1];
                b    = vec[0];
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_count == 3'd0);
            end
            default: ;
        endcase
    end

    // Vector index, hold counter and failure record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
        end else if (launch) begin
            vec       <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
        end else if (state == APPLY) begin
            if (last_hold) begin
                cnt <= '0;
                vec <= vec + 2'd1;
                if (mismatch) begin
                    fail_vec[vec] <= 1'b1;
                    err_count     <= err_count + 3'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_half_adder_bist.sv
// Scoreboard bench for half_adder_bist: two instances (HOLD_CYCLES 4 and 1)
// driving a behavioural half adder with selectable stuck-at faults.
module tb_half_adder_bist;

    localparam int unsigned H4 = 4;
    localparam int unsigned H1 = 1;

    typedef struct {
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
        int         len;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start4, start1;
    logic       a4, b4, sum4, cout4, busy4, done4, pass4;
    logic       a1, b1, sum1, cout1, busy1, done1, pass1;
    logic [2:0] err4, err1;
    logic [3:0] fv4, fv1;
    int         fault4;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q4[$];
    exp_t q1[$];
    int   run4 = 0;
    int   run1 = 0;
    logic done4_q = 1'b0;
    logic done1_q = 1'b0;

    half_adder_bist #(.HOLD_CYCLES(H4)) u_bist4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .sum(sum4), .cout(cout4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .fail_vec(fv4)
    );

    half_adder_bist #(.HOLD_CYCLES(H1)) u_bist1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .sum(sum1), .cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    // Adder under test: 0 good, 1 sum stuck-at-0, 2 cout stuck-at-1
    always_comb begin
        sum4  = a4 ^ b4;
        cout4 = a4 & b4;
        if (fault4 == 1) sum4 = 1'b0;
        if (fault4 == 2) cout4 = 1'b1;
        sum1  = a1 ^ b1;
        cout1 = a1 & b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the HOLD_CYCLES=4 instance
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        if (busy4) begin
            idx = run4 / H4;
            check("seq4_a", 32'(a4), 32'((idx >> 1) & 1));
            check("seq4_b", 32'(b4), 32'(idx & 1));
            run4++;
        end else if (!done4) begin
            run4 = 0;
        end
        check("pass4_without_done", 32'(pass4 & ~done4), 0);
        if (done4 && !done4_q) begin
            if (q4.size() == 0) begin
                check("sb4_unexpected_done", 1, 0);
            end else begin
                e = q4.pop_front();
                check("sb4_pass", 32'(pass4), 32'(e.pass));
                check("sb4_err_count", 32'(err4), 32'(e.err));
                check("sb4_fail_vec", 32'(fv4), 32'(e.fv));
                check("sb4_run_len", 32'(run4), 32'(e.len));
                check("sb4_ab_idle", 32'({a4, b4}), 0);
                check("sb4_busy_low", 32'(busy4), 0);
            end
            run4 = 0;
        end
        done4_q = done4;
    end

    // Monitor for the HOLD_CYCLES=1 instance
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        if (busy1) begin
            idx = run1 / H1;
            check("seq1_a", 32'(a1), 32'((idx >> 1) & 1));
            check("seq1_b", 32'(b1), 32'(idx & 1));
            run1++;
        end else if (!done1) begin
            run1 = 0;
        end
        check("pass1_without_done", 32'(pass1 & ~done1), 0);
        if (done1 && !done1_q) begin
            if (q1.size() == 0) begin
                check("sb1_unexpected_done", 1, 0);
            end else begin
                e = q1.pop_front();
                check("sb1_pass", 32'(pass1), 32'(e.pass));
                check("sb1_err_count", 32'(err1), 32'(e.err));
                check("sb1_fail_vec", 32'(fv1), 32'(e.fv));
                check("sb1_run_len", 32'(run1), 32'(e.len));
            end
            run1 = 0;
        end
        done1_q = done1;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a4"}, 32'(a4), 0);
        check({tag, "_b4"}, 32'(b4), 0);
        check({tag, "_busy4"}, 32'(busy4), 0);
        check({tag, "_done4"}, 32'(done4), 0);
        check({tag, "_pass4"}, 32'(pass4), 0);
        check({tag, "_err4"}, 32'(err4), 0);
        check({tag, "_fv4"}, 32'(fv4), 0);
        check({tag, "_busy1"}, 32'(busy1), 0);
        check({tag, "_done1"}, 32'(done1), 0);
        check({tag, "_err1"}, 32'(err1), 0);
    endtask

    task automatic wait_done4(input string tag);
        int n = 0;
        while (!done4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done4) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_start4();
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic run_h4(input int f, input logic p, input logic [2:0] ec, input logic [3:0] fv, input string tag);
        exp_t e;
        e.pass = p; e.err = ec; e.fv = fv; e.len = 16;
        fault4 = f;
        q4.push_back(e);
        pulse_start4();
        wait_done4(tag);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst_n  = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        fault4 = 0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy4", 32'(busy4), 0);
        check("idle_ab4", 32'({a4, b4}), 0);
        check("idle_done4", 32'(done4), 0);

        run_h4(0, 1'b1, 3'd0, 4'b0000, "good");
        run_h4(1, 1'b0, 3'd2, 4'b0110, "sum_sa0");

        // Restart straight from DONE with a good adder: results clear at once
        fault4 = 0;
        e.pass = 1'b1; e.err = 3'd0; e.fv = 4'b0000; e.len = 16;
        q4.push_back(e);
        pulse_start4();
        check("restart_done_low", 32'(done4), 0);
        check("restart_busy_high", 32'(busy4), 1);
        check("restart_err_cleared", 32'(err4), 0);
        check("restart_fv_cleared", 32'(fv4), 0);
        wait_done4("restart");

        run_h4(2, 1'b0, 3'd3, 4'b0111, "cout_sa1");

        // start toggled while vectors are applied must be ignored
        fault4 = 0;
        q4.push_back(e);
        pulse_start4();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start4 = ~start4;
        end
        start4 = 1'b0;
        wait_done4("toggle");

        // start held high: back-to-back runs, DONE for exactly one cycle
        q4.push_back(e);
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        wait_done4("b2b_first");
        @(negedge clk);
        check("b2b_done_one_cycle", 32'(done4), 0);
        check("b2b_busy_again", 32'(busy4), 1);
        start4 = 1'b0;
        wait_done4("b2b_second");

        // Asynchronous reset while vec2 is applied
        pulse_start4();
        repeat (9) @(negedge clk);
        check("mid_vec2_ab", 32'({a4, b4}), 32'(2));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_h4(0, 1'b1, 3'd0, 4'b0000, "after_reset");

        // HOLD_CYCLES=1 instance: done after 4 cycles
        e.len = 4;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done1) check("h1_timeout", 0, 1);

        repeat (3) @(negedge clk);
        check("sb4_drained", 32'(q4.size()), 0);
        check("sb1_drained", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/half_adder_bist.md
# half_adder_bist

Synthesizable built-in self-test controller for the combinational `half_adder_d`: it drives the DUT's `a`/`b` inputs through all four input combinations and checks the DUT's `sum`/`cout` responses against expected values. It sits directly beside the adder, with its outputs wired to the DUT inputs and the DUT outputs wired back in. Each vector is held for a programmable number of cycles, a per-vector pass/fail record is kept, and a pass verdict is reported at the end.

## Interface
- `HOLD_CYCLES`, default 4: number of clock cycles each vector is applied; legal range ≥1.

Ports:
- `clk`  input  1  single system clock; all state changes on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a test run; sampled only in IDLE and DONE.
- `a`  output  1  adder operand a, driven to the DUT.
- `b`  output  1  adder operand b, driven to the DUT.
- `sum`  input  1  DUT sum response.
- `cout`  input  1  DUT carry response.
- `busy`  output  1  high while vectors are being applied (APPLY state).
- `done`  output  1  level, high in DONE state.
- `pass`  output  1  high only in DONE when no vector failed.
- `err_count`  output  3  number of failing vectors, 0–4.
- `fail_vec`  output  4  bit i set if vector i mismatched.

## Operation
- States: IDLE, APPLY, DONE. Reset (rst_n=0, asynchronous) forces the following, immediately and regardless of clock:
  - state=IDLE, vector index=0, hold counter=0.
  - a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
- IDLE:
  - a=b=0.
  - `start`=1 at a rising edge → APPLY, vec=0, cnt=0, err_count and fail_vec cleared.
- APPLY:
  - a=vec[1], b=vec[0]. Order: vec0=(0,0), vec1=(0,1), vec2=(1,0), vec3=(1,1).
  - cnt increments each edge from 0 to HOLD_CYCLES-1.
  - On the edge where cnt==HOLD_CYCLES-1:
    - compare `sum` to a^b and `cout` to a&b (current a,b);
    - on any mismatch, set fail_vec[vec] and increment err_count;
    - cnt←0, vec←vec+1;
    - if vec==3, go to DONE instead.
  - `start` is ignored in APPLY.
- DONE:
  - a=b=0, done=1, busy=0, pass=(err_count==0).
  - fail_vec and err_count are held.
  - `start`=1 → restart exactly as from IDLE (results cleared on that edge, done drops).
- Sampling assumes the DUT is combinational: responses are valid in the same cycle the vector is driven.
- Outputs are registered or decoded from registered state only. No combinational path from `sum`/`cout` to any output.
- The hold counter is $clog2(HOLD_CYCLES) bits wide, with a minimum of 1 bit. It wraps only via the explicit reset to 0; it never overflows.
- err_count is the popcount of fail_vec by construction.

## Timing
- Edge 0 samples `start`=1:
  - busy=1 and a,b=(0,0) are visible after edge 0.
  - vec k is applied after edge k·HOLD_CYCLES and sampled at edge (k+1)·HOLD_CYCLES.
  - The final sample is at edge 4·HOLD_CYCLES. After that edge: busy=0, done=1, pass valid, a=b=0.
- Total run length is 4·HOLD_CYCLES cycles. With HOLD_CYCLES=1, the vector changes every cycle and done follows edge 4.
- pass and done rise in the same cycle; pass is never high while done is low.
- A restart from DONE at edge n gives done=0 and busy=1 after edge n.
- Reset mid-run: outputs go to reset values asynchronously. Nothing is retained; the next `start` runs all four vectors.
- A `start` held high continuously causes back-to-back runs: DONE lasts exactly one cycle between runs.

## Test plan
- Reset: rst_n=0 during any state → all outputs 0 without a clock edge. Release rst_n, no start → stays IDLE, a=b=0.
- Good DUT (half_adder_d), HOLD_CYCLES=4, 1-cycle start pulse:
  - a,b step 00,01,10,11, four cycles each;
  - busy high 16 cycles, then done=1, pass=1, err_count=0, fail_vec=4'b0000.
- Faulty model with sum stuck-at-0 → after 16 cycles: done=1, pass=0, err_count=2, fail_vec=4'b0110.
- Faulty model with cout stuck-at-1 → err_count=3, fail_vec=4'b0111, pass=0.
- Control:
  - start toggled during APPLY → sequence and timing unchanged;
  - start in DONE → results clear on that edge and a fresh 16-cycle run completes with correct results.
- Reset and parameter:
  - rst_n pulsed low while vec2 is applied → immediate reset values; next start gives full run, pass=1;
  - repeat the good-DUT run with HOLD_CYCLES=1 → done after 4 cycles, pass=1.
